// File: rtl/xadac_axi_burst_split.sv
// Splits AXI4 bursts into single-beat transactions for the dcache adapter.
// Read and write directions run independent FSMs; responses are reassembled upstream.
module xadac_axi_burst_split #(
    parameter int IdWidth   = 4,
    parameter int AddrWidth = 64,
    parameter int DataWidth = 64,
    parameter int UserWidth = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    // slave AR
    input  logic                   slv_ar_valid,
    output logic                   slv_ar_ready,
    input  logic [IdWidth-1:0]     slv_ar_id,
    input  logic [AddrWidth-1:0]   slv_ar_addr,
    input  logic [7:0]             slv_ar_len,
    input  logic [2:0]             slv_ar_size,
    input  logic [1:0]             slv_ar_burst,
    input  logic [UserWidth-1:0]   slv_ar_user,
    // slave R
    output logic                   slv_r_valid,
    input  logic                   slv_r_ready,
    output logic [IdWidth-1:0]     slv_r_id,
    output logic [DataWidth-1:0]   slv_r_data,
    output logic [1:0]             slv_r_resp,
    output logic                   slv_r_last,
    output logic [UserWidth-1:0]   slv_r_user,
    // slave AW
    input  logic                   slv_aw_valid,
    output logic                   slv_aw_ready,
    input  logic [IdWidth-1:0]     slv_aw_id,
    input  logic [AddrWidth-1:0]   slv_aw_addr,
    input  logic [7:0]             slv_aw_len,
    input  logic [2:0]             slv_aw_size,
    input  logic [1:0]             slv_aw_burst,
    input  logic [UserWidth-1:0]   slv_aw_user,
    // slave W
    input  logic                   slv_w_valid,
    output logic                   slv_w_ready,
    input  logic [DataWidth-1:0]   slv_w_data,
    input  logic [DataWidth/8-1:0] slv_w_strb,
    input  logic                   slv_w_last,
    input  logic [UserWidth-1:0]   slv_w_user,
    // slave B
    output logic                   slv_b_valid,
    input  logic                   slv_b_ready,
    output logic [IdWidth-1:0]     slv_b_id,
    output logic [1:0]             slv_b_resp,
    output logic [UserWidth-1:0]   slv_b_user,
    // master AR
    output logic                   mst_ar_valid,
    input  logic                   mst_ar_ready,
    output logic [IdWidth-1:0]     mst_ar_id,
    output logic [AddrWidth-1:0]   mst_ar_addr,
    output logic [7:0]             mst_ar_len,
    output logic [2:0]             mst_ar_size,
    output logic [1:0]             mst_ar_burst,
    output logic [UserWidth-1:0]   mst_ar_user,
    // master R
    input  logic                   mst_r_valid,
    output logic                   mst_r_ready,
    input  logic [IdWidth-1:0]     mst_r_id,
    input  logic [DataWidth-1:0]   mst_r_data,
    input  logic [1:0]             mst_r_resp,
    input  logic                   mst_r_last,
    input  logic [UserWidth-1:0]   mst_r_user,
    // master AW
    output logic                   mst_aw_valid,
    input  logic                   mst_aw_ready,
    output logic [IdWidth-1:0]     mst_aw_id,
    output logic [AddrWidth-1:0]   mst_aw_addr,
    output logic [7:0]             mst_aw_len,
    output logic [2:0]             mst_aw_size,
    output logic [1:0]             mst_aw_burst,
    output logic [UserWidth-1:0]   mst_aw_user,
    // master W
    output logic                   mst_w_valid,
    input  logic                   mst_w_ready,
    output logic [DataWidth-1:0]   mst_w_data,
    output logic [DataWidth/8-1:0] mst_w_strb,
    output logic                   mst_w_last,
    output logic [UserWidth-1:0]   mst_w_user,
    // master B
    input  logic                   mst_b_valid,
    output logic                   mst_b_ready,
    input  logic [IdWidth-1:0]     mst_b_id,
    input  logic [1:0]             mst_b_resp,
    input  logic [UserWidth-1:0]   mst_b_user
);
    // state     | meaning
    // R_IDLE    | waiting for an upstream AR
    // R_BUSY    | issuing single-beat ARs, forwarding R beats
    // W_IDLE    | waiting for an upstream AW
    // W_BUSY    | issuing AW+W pairs, absorbing early Bs
    // W_RESP    | all beats sent, collecting remaining Bs
    typedef enum logic       {R_IDLE, R_BUSY} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_BUSY, W_RESP} w_state_t;

    localparam logic [1:0] BurstFixed = 2'b00;
    localparam logic [1:0] BurstIncr  = 2'b01;
    localparam logic [1:0] BurstWrap  = 2'b10;

    function automatic logic [AddrWidth-1:0] beat_addr(
        input logic [AddrWidth-1:0] base,
        input logic [7:0]           len,
        input logic [2:0]           size,
        input logic [1:0]           burst,
        input logic [8:0]           n
    );
        logic [AddrWidth-1:0] offs, wmask, lower, res;
        offs  = AddrWidth'(n) << size;
        // legal wrap lengths are powers of two, so the modulo is a mask
        wmask = ((AddrWidth'(len) + AddrWidth'(1)) << size) - AddrWidth'(1);
        lower = base & ~wmask;
        case (burst)
            BurstFixed: res = base;
            BurstWrap:  res = lower + ((base - lower + offs) & wmask);
            default:    res = base + offs;
        endcase
        return res;
    endfunction

    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    r_state_t               r_state, r_state_d;
    logic [AddrWidth-1:0]   ar_addr_q;
    logic [7:0]             ar_len_q;
    logic [2:0]             ar_size_q;
    logic [1:0]             ar_burst_q;
    logic [IdWidth-1:0]     ar_id_q;
    logic [UserWidth-1:0]   ar_user_q;
    logic [8:0]             ar_cnt, r_cnt;

    w_state_t               w_state, w_state_d;
    logic [AddrWidth-1:0]   aw_addr_q;
    logic [7:0]             aw_len_q;
    logic [2:0]             aw_size_q;
    logic [1:0]             aw_burst_q;
    logic [IdWidth-1:0]     aw_id_q;
    logic [UserWidth-1:0]   aw_user_q;
    logic [8:0]             aw_cnt, b_cnt;
    logic                   aw_done, w_done;
    logic [1:0]             bresp_acc;

    logic slv_ar_hs, mst_ar_hs, r_hs;
    logic slv_aw_hs, mst_aw_hs, mst_w_hs, beat_done, b_hs, b_final, w_busy;

    logic unused_inputs;
    assign unused_inputs = ^{slv_w_last, mst_r_id, mst_r_last, mst_r_user, mst_b_id, mst_b_user};

    // read path
    assign slv_ar_ready = !rst && (r_state == R_IDLE);
    assign slv_ar_hs    = slv_ar_valid && slv_ar_ready;
    assign mst_ar_valid = (r_state == R_BUSY) && (ar_cnt <= {1'b0, ar_len_q});
    assign mst_ar_hs    = mst_ar_valid && mst_ar_ready;
    assign mst_ar_addr  = beat_addr(ar_addr_q, ar_len_q, ar_size_q, ar_burst_q, ar_cnt);
    assign mst_ar_len   = 8'd0;
    assign mst_ar_size  = ar_size_q;
    assign mst_ar_burst = BurstIncr;
    assign mst_ar_id    = ar_id_q;
    assign mst_ar_user  = ar_user_q;

    assign slv_r_valid  = (r_state == R_BUSY) && mst_r_valid;
    assign mst_r_ready  = (r_state == R_BUSY) && slv_r_ready;
    assign r_hs         = slv_r_valid && slv_r_ready;
    assign slv_r_data   = mst_r_data;
    assign slv_r_resp   = mst_r_resp;
    assign slv_r_id     = ar_id_q;
    assign slv_r_user   = ar_user_q;
    assign slv_r_last   = (r_cnt == {1'b0, ar_len_q});

    always_comb begin
        r_state_d = r_state;
        case (r_state)
            R_IDLE: if (slv_ar_hs) r_state_d = R_BUSY;
            R_BUSY: if (r_hs && slv_r_last) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= R_IDLE;
        else     r_state <= r_state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ar_addr_q  <= '0;
            ar_len_q   <= '0;
            ar_size_q  <= '0;
            ar_burst_q <= '0;
            ar_id_q    <= '0;
            ar_user_q  <= '0;
            ar_cnt     <= '0;
            r_cnt      <= '0;
        end else begin
            if (slv_ar_hs) begin
                ar_addr_q  <= slv_ar_addr;
                ar_len_q   <= slv_ar_len;
                ar_size_q  <= slv_ar_size;
                ar_burst_q <= slv_ar_burst;
                ar_id_q    <= slv_ar_id;
                ar_user_q  <= slv_ar_user;
                ar_cnt     <= '0;
                r_cnt      <= '0;
            end else begin
                if (mst_ar_hs) ar_cnt <= ar_cnt + 9'd1;
                if (r_hs)      r_cnt  <= r_cnt + 9'd1;
            end
        end
    end

    // write path
    assign w_busy       = (w_state == W_BUSY);
    assign slv_aw_ready = !rst && (w_state == W_IDLE);
    assign slv_aw_hs    = slv_aw_valid && slv_aw_ready;
    assign mst_aw_valid = w_busy && slv_w_valid && !aw_done;
    assign mst_aw_hs    = mst_aw_valid && mst_aw_ready;
    assign mst_aw_addr  = beat_addr(aw_addr_q, aw_len_q, aw_size_q, aw_burst_q, aw_cnt);
    assign mst_aw_len   = 8'd0;
    assign mst_aw_size  = aw_size_q;
    assign mst_aw_burst = BurstIncr;
    assign mst_aw_id    = aw_id_q;
    assign mst_aw_user  = aw_user_q;

    assign mst_w_valid  = w_busy && slv_w_valid && !w_done;
    assign mst_w_hs     = mst_w_valid && mst_w_ready;
    assign mst_w_data   = slv_w_data;
    assign mst_w_strb   = slv_w_strb;
    assign mst_w_user   = slv_w_user;
    assign mst_w_last   = 1'b1;
    // upstream beat is consumed only once both downstream channels have taken it
    assign beat_done    = w_busy && (aw_done || mst_aw_hs) && (w_done || mst_w_hs);
    assign slv_w_ready  = beat_done;

    assign b_final      = (b_cnt == {1'b0, aw_len_q});
    assign mst_b_ready  = (w_state != W_IDLE) && (b_final ? slv_b_ready : 1'b1);
    assign slv_b_valid  = (w_state != W_IDLE) && b_final && mst_b_valid;
    assign b_hs         = mst_b_valid && mst_b_ready;
    assign slv_b_resp   = resp_max(bresp_acc, mst_b_resp);
    assign slv_b_id     = aw_id_q;
    assign slv_b_user   = aw_user_q;

    always_comb begin
        w_state_d = w_state;
        case (w_state)
            W_IDLE: if (slv_aw_hs) w_state_d = W_BUSY;
            W_BUSY: if (beat_done && (aw_cnt == {1'b0, aw_len_q})) w_state_d = W_RESP;
            W_RESP: ;
            default: w_state_d = W_IDLE;
        endcase
        if ((w_state != W_IDLE) && b_hs && b_final) w_state_d = W_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) w_state <= W_IDLE;
        else     w_state <= w_state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_addr_q  <= '0;
            aw_len_q   <= '0;
            aw_size_q  <= '0;
            aw_burst_q <= '0;
            aw_id_q    <= '0;
            aw_user_q  <= '0;
            aw_cnt     <= '0;
            b_cnt      <= '0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            bresp_acc  <= 2'b00;
        end else if (slv_aw_hs) begin
            aw_addr_q  <= slv_aw_addr;
            aw_len_q   <= slv_aw_len;
            aw_size_q  <= slv_aw_size;
            aw_burst_q <= slv_aw_burst;
            aw_id_q    <= slv_aw_id;
            aw_user_q  <= slv_aw_user;
            aw_cnt     <= '0;
            b_cnt      <= '0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            bresp_acc  <= 2'b00;
        end else begin
            if (beat_done) begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
                aw_cnt  <= aw_cnt + 9'd1;
            end else begin
                if (mst_aw_hs) aw_done <= 1'b1;
                if (mst_w_hs)  w_done  <= 1'b1;
            end
            if ((w_state != W_IDLE) && b_hs && !b_final) begin
                bresp_acc <= resp_max(bresp_acc, mst_b_resp);
                b_cnt     <= b_cnt + 9'd1;
            end
        end
    end
endmodule

// File: tb/tb_xadac_axi_burst_split.sv
// Directed bench for xadac_axi_burst_split: both ports driven by hand, one cycle at a time.
module tb_xadac_axi_burst_split;
    logic        clk = 1'b0;
    logic        rst;
    logic        slv_ar_valid, slv_ar_ready;
    logic [3:0]  slv_ar_id;
    logic [63:0] slv_ar_addr;
    logic [7:0]  slv_ar_len;
    logic [2:0]  slv_ar_size;
    logic [1:0]  slv_ar_burst;
    logic [0:0]  slv_ar_user;
    logic        slv_r_valid, slv_r_ready;
    logic [3:0]  slv_r_id;
    logic [63:0] slv_r_data;
    logic [1:0]  slv_r_resp;
    logic        slv_r_last;
    logic [0:0]  slv_r_user;
    logic        slv_aw_valid, slv_aw_ready;
    logic [3:0]  slv_aw_id;
    logic [63:0] slv_aw_addr;
    logic [7:0]  slv_aw_len;
    logic [2:0]  slv_aw_size;
    logic [1:0]  slv_aw_burst;
    logic [0:0]  slv_aw_user;
    logic        slv_w_valid, slv_w_ready;
    logic [63:0] slv_w_data;
    logic [7:0]  slv_w_strb;
    logic        slv_w_last;
    logic [0:0]  slv_w_user;
    logic        slv_b_valid, slv_b_ready;
    logic [3:0]  slv_b_id;
    logic [1:0]  slv_b_resp;
    logic [0:0]  slv_b_user;
    logic        mst_ar_valid, mst_ar_ready;
    logic [3:0]  mst_ar_id;
    logic [63:0] mst_ar_addr;
    logic [7:0]  mst_ar_len;
    logic [2:0]  mst_ar_size;
    logic [1:0]  mst_ar_burst;
    logic [0:0]  mst_ar_user;
    logic        mst_r_valid, mst_r_ready;
    logic [3:0]  mst_r_id;
    logic [63:0] mst_r_data;
    logic [1:0]  mst_r_resp;
    logic        mst_r_last;
    logic [0:0]  mst_r_user;
    logic        mst_aw_valid, mst_aw_ready;
    logic [3:0]  mst_aw_id;
    logic [63:0] mst_aw_addr;
    logic [7:0]  mst_aw_len;
    logic [2:0]  mst_aw_size;
    logic [1:0]  mst_aw_burst;
    logic [0:0]  mst_aw_user;
    logic        mst_w_valid, mst_w_ready;
    logic [63:0] mst_w_data;
    logic [7:0]  mst_w_strb;
    logic        mst_w_last;
    logic [0:0]  mst_w_user;
    logic        mst_b_valid, mst_b_ready;
    logic [3:0]  mst_b_id;
    logic [1:0]  mst_b_resp;
    logic [0:0]  mst_b_user;

    int          n_total = 0;
    int          n_pass  = 0;
    logic [63:0] ea [0:7];
    logic [1:0]  brv [0:7];

    xadac_axi_burst_split dut (
        .clk(clk), .rst(rst),
        .slv_ar_valid(slv_ar_valid), .slv_ar_ready(slv_ar_ready), .slv_ar_id(slv_ar_id),
        .slv_ar_addr(slv_ar_addr), .slv_ar_len(slv_ar_len), .slv_ar_size(slv_ar_size),
        .slv_ar_burst(slv_ar_burst), .slv_ar_user(slv_ar_user),
        .slv_r_valid(slv_r_valid), .slv_r_ready(slv_r_ready), .slv_r_id(slv_r_id),
        .slv_r_data(slv_r_data), .slv_r_resp(slv_r_resp), .slv_r_last(slv_r_last),
        .slv_r_user(slv_r_user),
        .slv_aw_valid(slv_aw_valid), .slv_aw_ready(slv_aw_ready), .slv_aw_id(slv_aw_id),
        .slv_aw_addr(slv_aw_addr), .slv_aw_len(slv_aw_len), .slv_aw_size(slv_aw_size),
        .slv_aw_burst(slv_aw_burst), .slv_aw_user(slv_aw_user),
        .slv_w_valid(slv_w_valid), .slv_w_ready(slv_w_ready), .slv_w_data(slv_w_data),
        .slv_w_strb(slv_w_strb), .slv_w_last(slv_w_last), .slv_w_user(slv_w_user),
        .slv_b_valid(slv_b_valid), .slv_b_ready(slv_b_ready), .slv_b_id(slv_b_id),
        .slv_b_resp(slv_b_resp), .slv_b_user(slv_b_user),
        .mst_ar_valid(mst_ar_valid), .mst_ar_ready(mst_ar_ready), .mst_ar_id(mst_ar_id),
        .mst_ar_addr(mst_ar_addr), .mst_ar_len(mst_ar_len), .mst_ar_size(mst_ar_size),
        .mst_ar_burst(mst_ar_burst), .mst_ar_user(mst_ar_user),
        .mst_r_valid(mst_r_valid), .mst_r_ready(mst_r_ready), .mst_r_id(mst_r_id),
        .mst_r_data(mst_r_data), .mst_r_resp(mst_r_resp), .mst_r_last(mst_r_last),
        .mst_r_user(mst_r_user),
        .mst_aw_valid(mst_aw_valid), .mst_aw_ready(mst_aw_ready), .mst_aw_id(mst_aw_id),
        .mst_aw_addr(mst_aw_addr), .mst_aw_len(mst_aw_len), .mst_aw_size(mst_aw_size),
        .mst_aw_burst(mst_aw_burst), .mst_aw_user(mst_aw_user),
        .mst_w_valid(mst_w_valid), .mst_w_ready(mst_w_ready), .mst_w_data(mst_w_data),
        .mst_w_strb(mst_w_strb), .mst_w_last(mst_w_last), .mst_w_user(mst_w_user),
        .mst_b_valid(mst_b_valid), .mst_b_ready(mst_b_ready), .mst_b_id(mst_b_id),
        .mst_b_resp(mst_b_resp), .mst_b_user(mst_b_user)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_issue(input logic [63:0] a, input logic [7:0] len, input logic [1:0] burst,
                            input logic [3:0] id);
        slv_ar_valid = 1'b1; slv_ar_addr = a; slv_ar_len = len; slv_ar_size = 3'd3;
        slv_ar_burst = burst; slv_ar_id = id;
        #1;
        chk("ar_accept", slv_ar_ready, 1);
        step();
        slv_ar_valid = 1'b0;
    endtask

    task automatic rd_addrs(input int n, input logic [3:0] id);
        for (int i = 0; i < n; i++) begin
            mst_ar_ready = 1'b1;
            #1;
            chk("mst_ar_valid", mst_ar_valid, 1);
            chk("mst_ar_addr", mst_ar_addr, ea[i]);
            chk("mst_ar_len", mst_ar_len, 0);
            chk("mst_ar_id", mst_ar_id, id);
            step();
        end
        mst_ar_ready = 1'b0;
    endtask

    task automatic rd_data(input int n, input logic [3:0] id, input bit bp, input logic [63:0] d0);
        for (int i = 0; i < n; i++) begin
            mst_r_valid = 1'b1;
            mst_r_data  = d0 + 64'(i);
            if (bp && i[0]) begin
                slv_r_ready = 1'b0;
                #1;
                chk("r_hold_valid", slv_r_valid, 1);
                chk("r_hold_ready", mst_r_ready, 0);
                step();
            end
            slv_r_ready = 1'b1;
            #1;
            chk("slv_r_valid", slv_r_valid, 1);
            chk("slv_r_data", slv_r_data, d0 + 64'(i));
            chk("slv_r_id", slv_r_id, id);
            chk("slv_r_last", slv_r_last, (i == n - 1));
            step();
        end
        mst_r_valid = 1'b0;
        slv_r_ready = 1'b0;
        #1;
        chk("rd_back_idle", slv_ar_ready, 1);
    endtask

    task automatic wr_beat(input int i, input logic [63:0] exp_addr, input bit split);
        slv_w_valid = 1'b1;
        slv_w_data  = 64'hA000 + 64'(i);
        slv_w_strb  = 8'hff;
        if (split) begin
            mst_aw_ready = 1'b1; mst_w_ready = 1'b0;
            #1;
            chk("split_aw_valid", mst_aw_valid, 1);
            chk("split_aw_addr", mst_aw_addr, exp_addr);
            chk("split_w_ready_lo", slv_w_ready, 0);
            step();
            mst_aw_ready = 1'b0; mst_w_ready = 1'b1;
            #1;
            chk("split_aw_done", mst_aw_valid, 0);
            chk("split_w_valid", mst_w_valid, 1);
            chk("split_w_ready_hi", slv_w_ready, 1);
        end else begin
            mst_aw_ready = 1'b1; mst_w_ready = 1'b1;
            #1;
            chk("mst_aw_valid", mst_aw_valid, 1);
            chk("mst_aw_addr", mst_aw_addr, exp_addr);
            chk("mst_w_valid", mst_w_valid, 1);
            chk("slv_w_ready", slv_w_ready, 1);
        end
        chk("mst_w_data", mst_w_data, 64'hA000 + 64'(i));
        chk("mst_w_last", mst_w_last, 1);
        step();
        slv_w_valid = 1'b0; mst_aw_ready = 1'b0; mst_w_ready = 1'b0;
    endtask

    task automatic wr_b(input int n, input logic [3:0] id, input logic [1:0] exp_resp);
        for (int i = 0; i < n - 1; i++) begin
            mst_b_valid = 1'b1; mst_b_resp = brv[i]; slv_b_ready = 1'b0;
            #1;
            chk("b_absorb_ready", mst_b_ready, 1);
            chk("b_absorb_hidden", slv_b_valid, 0);
            step();
        end
        mst_b_valid = 1'b1; mst_b_resp = brv[n-1]; slv_b_ready = 1'b1;
        #1;
        chk("slv_b_valid", slv_b_valid, 1);
        chk("slv_b_id", slv_b_id, id);
        chk("slv_b_resp", slv_b_resp, exp_resp);
        step();
        mst_b_valid = 1'b0; slv_b_ready = 1'b0;
        #1;
        chk("wr_back_idle", slv_aw_ready, 1);
        chk("b_single", slv_b_valid, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        slv_ar_valid = 0; slv_ar_id = 0; slv_ar_addr = 0; slv_ar_len = 0; slv_ar_size = 0;
        slv_ar_burst = 0; slv_ar_user = 0; slv_r_ready = 0;
        slv_aw_valid = 0; slv_aw_id = 0; slv_aw_addr = 0; slv_aw_len = 0; slv_aw_size = 0;
        slv_aw_burst = 0; slv_aw_user = 0;
        slv_w_valid = 0; slv_w_data = 0; slv_w_strb = 0; slv_w_last = 0; slv_w_user = 0;
        slv_b_ready = 0;
        mst_ar_ready = 0; mst_r_valid = 0; mst_r_id = 0; mst_r_data = 0; mst_r_resp = 0;
        mst_r_last = 0; mst_r_user = 0; mst_aw_ready = 0; mst_w_ready = 0;
        mst_b_valid = 0; mst_b_id = 0; mst_b_resp = 0; mst_b_user = 0;
        #3;
        chk("rst_ar_ready", slv_ar_ready, 0);
        chk("rst_aw_ready", slv_aw_ready, 0);
        chk("rst_mst_ar_valid", mst_ar_valid, 0);
        chk("rst_mst_aw_valid", mst_aw_valid, 0);
        chk("rst_slv_b_valid", slv_b_valid, 0);
        step(); step();
        rst = 1'b0;
        #1;
        chk("idle_ar_ready", slv_ar_ready, 1);
        chk("idle_aw_ready", slv_aw_ready, 1);

        // single-beat read
        rd_issue(64'h1000, 8'd0, 2'b01, 4'd5);
        chk("busy_ar_ready", slv_ar_ready, 0);
        ea[0] = 64'h1000;
        rd_addrs(1, 4'd5);
        #1;
        chk("single_ar_done", mst_ar_valid, 0);
        rd_data(1, 4'd5, 1'b0, 64'hD0);

        // INCR read with R back-pressure
        rd_issue(64'h2000, 8'd3, 2'b01, 4'd6);
        ea[0] = 64'h2000; ea[1] = 64'h2008; ea[2] = 64'h2010; ea[3] = 64'h2018;
        rd_addrs(4, 4'd6);
        #1;
        chk("incr_ar_done", mst_ar_valid, 0);
        rd_data(4, 4'd6, 1'b1, 64'hD100);

        // WRAP read
        rd_issue(64'h3018, 8'd3, 2'b10, 4'd1);
        ea[0] = 64'h3018; ea[1] = 64'h3000; ea[2] = 64'h3008; ea[3] = 64'h3010;
        rd_addrs(4, 4'd1);
        rd_data(4, 4'd1, 1'b0, 64'hD200);

        // INCR write, beat 1 granted AW and W in separate cycles
        slv_aw_valid = 1'b1; slv_aw_addr = 64'h4000; slv_aw_len = 8'd2; slv_aw_size = 3'd3;
        slv_aw_burst = 2'b01; slv_aw_id = 4'd7;
        #1;
        chk("aw_accept", slv_aw_ready, 1);
        step();
        slv_aw_valid = 1'b0;
        #1;
        chk("aw_busy", slv_aw_ready, 0);
        wr_beat(0, 64'h4000, 1'b0);
        wr_beat(1, 64'h4008, 1'b1);
        wr_beat(2, 64'h4010, 1'b0);
        #1;
        chk("wresp_no_aw", mst_aw_valid, 0);
        brv[0] = 2'b00; brv[1] = 2'b00; brv[2] = 2'b00;
        wr_b(3, 4'd7, 2'b00);

        // write with SLVERR on 2nd B, concurrent read accepted in the same cycle
        slv_aw_valid = 1'b1; slv_aw_addr = 64'h7000; slv_aw_len = 8'd3; slv_aw_size = 3'd3;
        slv_aw_burst = 2'b01; slv_aw_id = 4'd9;
        slv_ar_valid = 1'b1; slv_ar_addr = 64'h8000; slv_ar_len = 8'd1; slv_ar_size = 3'd3;
        slv_ar_burst = 2'b01; slv_ar_id = 4'd3;
        #1;
        chk("both_aw_ready", slv_aw_ready, 1);
        chk("both_ar_ready", slv_ar_ready, 1);
        step();
        slv_aw_valid = 1'b0; slv_ar_valid = 1'b0;
        wr_beat(0, 64'h7000, 1'b0);
        wr_beat(1, 64'h7008, 1'b0);
        wr_beat(2, 64'h7010, 1'b0);
        wr_beat(3, 64'h7018, 1'b0);
        #1;
        chk("conc_rd_ar_valid", mst_ar_valid, 1);
        chk("conc_rd_ar_addr", mst_ar_addr, 64'h8000);
        brv[0] = 2'b00; brv[1] = 2'b10; brv[2] = 2'b00; brv[3] = 2'b00;
        wr_b(4, 4'd9, 2'b10);
        ea[0] = 64'h8000; ea[1] = 64'h8008;
        rd_addrs(2, 4'd3);
        rd_data(2, 4'd3, 1'b1, 64'hE0);

        // reset in the middle of an 8-beat read
        rd_issue(64'h5000, 8'd7, 2'b01, 4'd2);
        ea[0] = 64'h5000; ea[1] = 64'h5008; ea[2] = 64'h5010;
        rd_addrs(3, 4'd2);
        mst_r_valid = 1'b1; mst_r_data = 64'hF0; slv_r_ready = 1'b1;
        #1;
        chk("mid_r_valid", slv_r_valid, 1);
        chk("mid_r_last", slv_r_last, 0);
        step();
        chk("mid_ar_pending", mst_ar_valid, 1);
        rst = 1'b1;
        #1;
        chk("rst_drop_ar_valid", mst_ar_valid, 0);
        chk("rst_drop_r_valid", slv_r_valid, 0);
        chk("rst_drop_r_ready", mst_r_ready, 0);
        chk("rst_drop_ar_ready", slv_ar_ready, 0);
        mst_r_valid = 1'b0; slv_r_ready = 1'b0;
        step();
        rst = 1'b0;
        #1;
        chk("post_rst_ar_ready", slv_ar_ready, 1);
        chk("post_rst_ar_valid", mst_ar_valid, 0);
        rd_issue(64'h6000, 8'd1, 2'b01, 4'd4);
        ea[0] = 64'h6000; ea[1] = 64'h6008;
        rd_addrs(2, 4'd4);
        rd_data(2, 4'd4, 1'b0, 64'hC0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/xadac_axi_burst_split.md
Name: xadac_axi_burst_split

Overview:
- Sits directly upstream of the AXI-to-dcache adapter, which only handles single-beat AXI transactions.
- Accepts full AXI4 bursts on its slave port (FIXED, INCR, WRAP; len 0..255).
- Splits each burst into len+1 single-beat transactions on its master port and reassembles the responses: R beats get the original ID and a correct r_last; write B responses collapse into a single B.
- One read burst and one write burst may be in flight at once; the two directions are independent.

Parameters:
IdWidth, 4, AXI ID width on both ports
AddrWidth, 64, AXI address width
DataWidth, 64, AXI data width (one beat = one dcache word)
UserWidth, 1, AXI user width

Ports:
clk  input  1  clock; all state on rising edge
rst  input  1  asynchronous, active-high reset
slv  AXI_BUS.Slave  IdWidth/AddrWidth/DataWidth/UserWidth  burst-capable upstream port
mst  AXI_BUS.Master  same widths  single-beat port to the dcache adapter

Behaviour:
- Reset: read FSM R_IDLE, write FSM W_IDLE, all counters 0, done flags 0, accumulated bresp 0. While rst is high, every valid/ready output is 0.
- Read FSM, states R_IDLE and R_BUSY:
  - R_IDLE: slv.ar_ready=1. On an AR handshake, latch addr, len, size, burst, id, user; set ar_cnt=r_cnt=0; go to R_BUSY.
  - R_BUSY: slv.ar_ready=0. mst.ar_valid=(ar_cnt<=len), ar_addr=beat_addr(ar_cnt), ar_len=0, ar_size=latched size, ar_burst=INCR, ar_id/ar_user=latched. Each mst AR handshake increments ar_cnt.
  - R path is combinational pass-through: slv.r_valid=mst.r_valid, mst.r_ready=slv.r_ready, data/resp pass through, r_id and r_user come from the latched values, r_last=(r_cnt==len). Each R handshake increments r_cnt.
  - The handshake with r_last=1 returns the FSM to R_IDLE. ARs may run ahead of Rs.
- beat_addr(n), computed modulo 2^AddrWidth:
  - FIXED: base.
  - INCR: base + (n<<size).
  - WRAP: lower = base aligned down to (len+1)<<size; the beat address is lower + ((base - lower + (n<<size)) mod ((len+1)<<size)).
  - No 4KB-boundary check is made.
- Write FSM, states W_IDLE, W_BUSY and W_RESP:
  - W_IDLE: slv.aw_ready=1. On an AW handshake, latch the AW fields; set aw_cnt=0, b_cnt=0, bresp_acc=OKAY; go to W_BUSY.
  - W_BUSY, per beat: mst.aw_valid=slv.w_valid && !aw_done, with the address from beat_addr(aw_cnt) and len 0. mst.w_valid=slv.w_valid && !w_done; w_data/w_strb/w_user pass through; mst.w_last=1.
    - slv.w_ready is high only in the cycle the beat completes, i.e. both AW and W downstream handshakes are done (this cycle or earlier, tracked by aw_done/w_done). On completion clear both flags and increment aw_cnt.
    - This handles both a same-cycle AW+W grant and split grants. slv.w_last is not checked.
    - After beat len completes, go to W_RESP.
  - B handling (W_BUSY and W_RESP): for non-final B, mst.b_ready=1 and the B is absorbed. bresp_acc=max(bresp_acc, b_resp), with SLVERR/DECERR taking priority. b_cnt increments.
  - Final B (b_cnt==len): slv.b_valid=mst.b_valid, mst.b_ready=slv.b_ready, b_resp=max(bresp_acc, mst.b_resp), b_id/b_user latched. Its handshake returns the FSM to W_IDLE.
- Counters are 9 bits wide to cover len=255 (256 beats).
- Simultaneous events: an AR and an AW accepted in the same cycle are both taken. An AR/R or AW/B handshake landing in the same cycle is counted once each.
- len=0: behaves as a transparent single-beat path with one cycle of AR/AW acceptance latency.
- Reset mid-burst: everything is dropped, FSMs return to idle, no responses are emitted. The downstream adapter shares rst.

Test Plan:
- Single read, AR addr=0x1000 len=0 size=3 id=5 -> one mst AR at 0x1000; slv R id=5, r_last=1.
- INCR read, addr=0x2000 len=3 size=3 -> mst ARs at 0x2000/08/10/18; slv R beats carry r_last only on the 4th beat; data order preserved with downstream r_ready back-pressure toggling.
- WRAP read, addr=0x3018 len=3 size=3 -> mst ARs at 0x3018, 0x3000, 0x3008, 0x3010.
- INCR write, addr=0x4000 len=2, with the downstream granting AW and W in separate cycles on beat 1 -> 3 mst AW+W pairs; exactly one slv B, with the original id.
- Write, len=3, where the 2nd downstream B is SLVERR -> single slv B with resp=SLVERR. Concurrent read burst is unaffected.
- Assert rst in the middle of an 8-beat read -> all valids drop immediately; after release slv.ar_ready=1 and a new burst completes normally.
